// File: rtl/acc_issue_gate.sv
//==============================================================================
// Module   : acc_issue_gate
// Purpose  : Issue gate between decode and the accelerator port. While
//            accelerator bypass mode is active it accepts one instruction per
//            valid/ready handshake. It forwards the instruction as a one-cycle
//            registered strobe, then blocks further issue for BUSY_CYCLES
//            cycles.
// Ports    : clk, reset_n (async, active-low)
//            accbypass          - bypass enable; low aborts synchronously
//            in_valid/in_instr  - upstream instruction handshake
//            in_ready           - gate can accept this cycle (combinational)
//            acc_done           - accelerator early completion
//            accbypassA         - registered issue strobe
//            fullinstructionA   - registered instruction, zero when idle
//            busy               - gate is inside its busy window
//            issue_count        - issues since reset, wraps
// Options  : define ACC_EARLY_DONE_EN so that acc_done ends the busy window
//            early. Otherwise acc_done is ignored.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module acc_issue_gate #(
  parameter int INSTR_W     = 32,
  parameter int BUSY_CYCLES = 3,
  parameter int BUSY_W      = 4,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               accbypass,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               in_ready,
  input  logic               acc_done,
  output logic               accbypassA,
  output logic [INSTR_W-1:0] fullinstructionA,
  output logic               busy,
  output logic [CNT_W-1:0]   issue_count
);

  localparam logic [BUSY_W-1:0] BUSY_LOAD = BUSY_W'(BUSY_CYCLES);
  localparam logic [BUSY_W-1:0] BUSY_LAST = BUSY_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [BUSY_W-1:0] busy_cnt, busy_cnt_nxt;
  logic              accept;

`ifndef ACC_EARLY_DONE_EN
  // acc_done is kept on the interface so both builds share one pinout.
  logic unused_acc_done;
  assign unused_acc_done = acc_done;
`endif

  // Gating by reset_n means ready drops as soon as reset asserts, without
  // waiting for the state register to clear.
  assign in_ready = (state == ST_IDLE) & accbypass & reset_n;
  assign accept   = in_valid & in_ready;
  assign busy     = (state == ST_BUSY);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      busy_cnt <= '0;
    end else begin
      state    <= state_nxt;
      busy_cnt <= busy_cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt    = state;
    busy_cnt_nxt = busy_cnt;
    if (!accbypass) begin
      // Leaving bypass mode cancels any window in progress.
      state_nxt    = ST_IDLE;
      busy_cnt_nxt = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // With a zero window the gate never leaves IDLE, so issue can
          // happen on back-to-back cycles.
          if (accept && (BUSY_CYCLES > 0)) begin
            state_nxt    = ST_BUSY;
            busy_cnt_nxt = BUSY_LOAD;
          end
        end
        ST_BUSY: begin
          if (busy_cnt == BUSY_LAST) begin
            state_nxt    = ST_IDLE;
            busy_cnt_nxt = '0;
          end else begin
            busy_cnt_nxt = busy_cnt - BUSY_LAST;
          end
`ifdef ACC_EARLY_DONE_EN
          if (acc_done) begin
            state_nxt    = ST_IDLE;
            busy_cnt_nxt = '0;
          end
`endif
        end
        default: begin
          state_nxt    = ST_IDLE;
          busy_cnt_nxt = '0;
        end
      endcase
    end
  end

  // Issue strobe, instruction register and counter. accept already includes
  // accbypass, so an abort suppresses the strobe without extra terms.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      accbypassA       <= 1'b0;
      fullinstructionA <= '0;
      issue_count      <= '0;
    end else begin
      accbypassA       <= accept;
      fullinstructionA <= accept ? in_instr : '0;
      issue_count      <= issue_count + CNT_W'(accept);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_acc_issue_gate.sv
//==============================================================================
// Module   : tb_acc_issue_gate
// Purpose  : Self-checking bench for acc_issue_gate. It uses two instances:
//            the default configuration, and a zero-window gate with a 2-bit
//            counter. Both are compared against a timestamp-based reference
//            model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_acc_issue_gate;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        accbypass = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic        acc_done = 1'b0;

  logic        rdy0, s0, busy0;
  logic [31:0] i0;
  logic [15:0] cnt0;
  logic        rdy1, s1, busy1;
  logic [31:0] i1;
  logic [1:0]  cnt1;

  always #5 clk = ~clk;

  acc_issue_gate #(.INSTR_W(32), .BUSY_CYCLES(3), .BUSY_W(4), .CNT_W(16)) dut0 (
    .clk(clk), .reset_n(reset_n), .accbypass(accbypass), .in_valid(in_valid),
    .in_instr(in_instr), .in_ready(rdy0), .acc_done(acc_done),
    .accbypassA(s0), .fullinstructionA(i0), .busy(busy0), .issue_count(cnt0)
  );

  acc_issue_gate #(.INSTR_W(32), .BUSY_CYCLES(0), .BUSY_W(4), .CNT_W(2)) dut1 (
    .clk(clk), .reset_n(reset_n), .accbypass(accbypass), .in_valid(in_valid),
    .in_instr(in_instr), .in_ready(rdy1), .acc_done(acc_done),
    .accbypassA(s1), .fullinstructionA(i1), .busy(busy1), .issue_count(cnt1)
  );

  // Reference model. Each gate keeps the index of the earliest clock edge at
  // which it may accept again; it is busy at every edge before that index.
  int          vectors = 0;
  int          miscompares = 0;
  int          nxt = 0;              // index of the upcoming rising edge
  int          wnd[2]   = '{3, 0};   // busy window per instance
  int          cmask[2] = '{32'hFFFF, 32'h3};
  int          rdy_edge[2];
  int          mcnt[2];
  bit          m_s[2];
  logic [31:0] m_i[2];

  task automatic chk(input string tag, input int k, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s[dut%0d] observed=%h expected=%h (edge %0d)", tag, k, obs, exp, nxt);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      rdy_edge[k] = 0;
      mcnt[k]     = 0;
      m_s[k]      = 1'b0;
      m_i[k]      = '0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      bit acc;
      acc = in_valid && accbypass && reset_n && (nxt >= rdy_edge[k]);
      m_s[k] = acc;
      m_i[k] = acc ? in_instr : 32'h0;
      if (!accbypass) begin
        rdy_edge[k] = nxt + 1;
      end else if (acc) begin
        mcnt[k]     = (mcnt[k] + 1) & cmask[k];
        rdy_edge[k] = nxt + wnd[k] + 1;
      end
`ifdef ACC_EARLY_DONE_EN
      else if (acc_done && (nxt < rdy_edge[k])) begin
        rdy_edge[k] = nxt + 1;
      end
`endif
    end
    nxt++;
  endtask

  task automatic check_ready();
    chk("in_ready", 0, {31'b0, rdy0}, {31'b0, accbypass && reset_n && (nxt >= rdy_edge[0])});
    chk("in_ready", 1, {31'b0, rdy1}, {31'b0, accbypass && reset_n && (nxt >= rdy_edge[1])});
  endtask

  task automatic check_out();
    chk("strobe", 0, {31'b0, s0}, {31'b0, m_s[0]});
    chk("instr",  0, i0, m_i[0]);
    chk("busy",   0, {31'b0, busy0}, {31'b0, reset_n && (nxt < rdy_edge[0])});
    chk("count",  0, {16'b0, cnt0}, mcnt[0]);
    chk("strobe", 1, {31'b0, s1}, {31'b0, m_s[1]});
    chk("instr",  1, i1, m_i[1]);
    chk("busy",   1, {31'b0, busy1}, {31'b0, reset_n && (nxt < rdy_edge[1])});
    chk("count",  1, {30'b0, cnt1}, mcnt[1]);
  endtask

  // One clock cycle: drive on the falling edge, check ready mid-cycle, let the
  // rising edge happen, then check the registered outputs just after it.
  task automatic step(input bit byp, input bit vld, input logic [31:0] ins, input bit dn);
    @(negedge clk);
    reset_n   = 1'b1;
    accbypass = byp;
    in_valid  = vld;
    in_instr  = ins;
    acc_done  = dn;
    #1 check_ready();
    @(posedge clk);
    model_edge();
    #1 check_out();
  endtask

  initial begin
    model_reset();
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_out();
    check_ready();

    // Single issue with the full busy window
    step(1, 1, 32'hDEADBEEF, 0);
    repeat (4) step(1, 0, 32'h0, 0);

    // Continuous stream: the default gate accepts every 4th edge; the zero-window
    // gate accepts every edge, so its 2-bit counter wraps.
    for (int n = 0; n < 16; n++) step(1, 1, 32'h1000_0000 + n, 0);
    repeat (4) step(1, 0, 32'h0, 0);

    // Abort inside the busy window, then re-enable and accept at once
    step(1, 1, 32'hCAFE0001, 0);
    step(1, 0, 32'h0, 0);
    step(1, 0, 32'h0, 0);
    step(0, 1, 32'hCAFE0002, 0);
    step(1, 1, 32'hCAFE0003, 0);
    repeat (4) step(1, 0, 32'h0, 0);

    // Asynchronous reset while the strobe is high
    step(1, 1, 32'h55AA55AA, 0);
    #2 reset_n = 1'b0;
    #1 model_reset();
    check_out();
    check_ready();

    // Early completion on the first busy cycle
    step(1, 1, 32'hA5A5A5A5, 0);
    step(1, 1, 32'h0BAD0BAD, 1);
    repeat (4) step(1, 1, 32'h0BAD0BAD, 0);
    repeat (4) step(1, 0, 32'h0, 0);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, $urandom,
           $urandom_range(0, 4) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/acc_issue_gate.md
Name: acc_issue_gate

Overview:
- Parametrised accelerator issue gate between decode and the accelerator port.
- Accepts instructions via valid/ready handshake while accelerator bypass mode is active.
- Forwards each instruction to the accelerator as a one-cycle registered pulse, then blocks further issue for a programmable busy window.
- Generalises the fixed 32-bit / 3-cycle gate: configurable width and window, backpressure, issue counter, optional early release.

Parameters:
- INSTR_W, 32, instruction width in bits.
- BUSY_CYCLES, 3, cycles blocked after each issue pulse; 0 permits back-to-back issue.
- BUSY_W, 4, busy down-counter width; must satisfy 2^BUSY_W > BUSY_CYCLES.
- CNT_W, 16, issue counter width.

Ports:
- clk  input  1  sole clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- accbypass  input  1  bypass mode enable; deassertion aborts synchronously.
- in_valid  input  1  upstream instruction valid.
- in_instr  input  INSTR_W  upstream instruction.
- in_ready  output  1  gate can accept an instruction this cycle.
- acc_done  input  1  accelerator early completion (used only with ACC_EARLY_DONE_EN).
- accbypassA  output  1  registered issue strobe to accelerator.
- fullinstructionA  output  INSTR_W  registered instruction to accelerator; zero when not issuing.
- busy  output  1  gate is in the busy window.
- issue_count  output  CNT_W  number of issues since reset.

Behaviour:
- Reset (reset_n low, asynchronous): all outputs and state are zero.
  - State = IDLE, busy counter = 0, issue_count = 0.
  - Deassertion of reset_n is synchronised externally.
- States: IDLE, BUSY.
- in_ready = (state == IDLE) & accbypass & reset_n. This is combinational, with no dependency on in_valid.
- Accept = in_valid & in_ready, sampled at rising edge N.
  - During cycle N+1: accbypassA = 1 and fullinstructionA = in_instr captured at edge N. Latency is 1 cycle.
  - At every other time: accbypassA = 0 and fullinstructionA = 0. The strobe lasts exactly one cycle.
  - issue_count increments on accept and wraps modulo 2^CNT_W (0xFFFF -> 0x0000 at default).
- IDLE -> BUSY on accept when BUSY_CYCLES > 0; the counter loads BUSY_CYCLES.
- With BUSY_CYCLES = 0, the gate stays in IDLE. Accepts may occur every cycle, and accbypassA may stay high on consecutive cycles.
- BUSY:
  - Counter decrements each cycle.
  - When the counter equals 1, the next state is IDLE.
  - busy = 1 throughout BUSY and in_ready = 0.
  - Issue pulses are therefore separated by at least BUSY_CYCLES + 1 cycles. At default, accepts can occur at edges N and N+4 at the earliest.
- accbypass low at any edge (synchronous abort): next state IDLE, counter 0, accbypassA = 0, fullinstructionA = 0, no accept. issue_count is retained.
- accbypass low in the same cycle as in_valid: in_ready = 0, so no accept.
- Abort during BUSY: the window ends immediately. When accbypass returns high, in_ready = 1 in that same cycle.
- in_valid and in_instr are ignored while in_ready = 0. Upstream must hold them stable until accepted.
- reset_n low mid-BUSY or mid-pulse: outputs clear immediately (asynchronous), without waiting for a clock edge.

Optional Feature:
- Macro: ACC_EARLY_DONE_EN.
- Defined: acc_done = 1 sampled in BUSY forces next state IDLE and counter 0. in_ready rises the following cycle.
  - acc_done in IDLE is ignored.
  - acc_done coincident with the counter's last cycle behaves as a normal exit.
- Undefined: acc_done is ignored. The port still exists so the interface is identical.

Test Plan:
- Reset then accbypass=1, in_valid=1, in_instr=0xDEADBEEF at edge 1 -> accbypassA=1, fullinstructionA=0xDEADBEEF in cycle 2 only. busy=1 in cycles 2-4. in_ready=1 again in cycle 5. issue_count=1.
- in_valid held high with an instruction stream -> accepts at edges 1, 5, 9, 13. Exactly one strobe per 4 cycles. issue_count=4.
- accbypass dropped during busy cycle 3 -> outputs 0 next cycle. Re-raise accbypass -> in_ready=1 that cycle, and an accept is possible immediately.
- reset_n pulled low mid-strobe, asynchronous to clk -> accbypassA, fullinstructionA, busy and issue_count go to 0 before the next edge.
- BUSY_CYCLES=0 and CNT_W=2 with 5 consecutive accepts -> accbypassA high for 5 consecutive cycles. issue_count sequence 1, 2, 3, 0, 1.
- With ACC_EARLY_DONE_EN, acc_done=1 in the first busy cycle -> in_ready=1 one cycle later. Without the macro -> full 3-cycle window.
